// File: rtl/apb_vgachargen_bridge.sv
// APB3 slave bridging bus transfers onto the vgachargen character-map, colour-map and font ports.
// Every transfer is setup -> ISSUE (one wait state) -> RESP.
module apb_vgachargen_bridge #(
  parameter int unsigned CH_MAP_DEPTH  = 600,
  parameter int unsigned COL_MAP_DEPTH = 600,
  parameter int unsigned TIFF_DEPTH    = 1024,
  parameter int unsigned MEM_ADDR_W    = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           paddr_i,
  input  logic [31:0]           pwdata_i,
  input  logic [3:0]            pstrb_i,
  output logic                  pready_o,
  output logic [31:0]           prdata_o,
  output logic                  pslverr_o,
  output logic [MEM_ADDR_W-1:0] char_map_addr_o,
  output logic                  char_map_we_o,
  output logic [3:0]            char_map_be_o,
  output logic [31:0]           char_map_wdata_o,
  input  logic [31:0]           char_map_rdata_i,
  output logic [MEM_ADDR_W-1:0] col_map_addr_o,
  output logic                  col_map_we_o,
  output logic [3:0]            col_map_be_o,
  output logic [31:0]           col_map_wdata_o,
  input  logic [31:0]           col_map_rdata_i,
  output logic [MEM_ADDR_W-1:0] char_tiff_addr_o,
  output logic                  char_tiff_we_o,
  output logic [31:0]           char_tiff_wdata_o,
  input  logic [31:0]           char_tiff_rdata_i
);

  localparam int unsigned IDX_W = 10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  state_e state_q, state_d;
  logic [1:0] region_q, region_d;
  logic write_q, write_d, err_q, err_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d;
  logic [MEM_ADDR_W-1:0] cm_addr_q, cm_addr_d, col_addr_q, col_addr_d, tf_addr_q, tf_addr_d;
  logic [3:0] cm_be_q, cm_be_d, col_be_q, col_be_d;
  logic [31:0] cm_wdata_q, cm_wdata_d, col_wdata_q, col_wdata_d, tf_wdata_q, tf_wdata_d;
  logic cm_we_q, cm_we_d, col_we_q, col_we_d, tf_we_q, tf_we_d;

  logic setup_c, err_c, we_c, range_err_c, unused_c;
  logic [1:0] region_c;
  logic [IDX_W-1:0] idx_c;

  assign unused_c = ^paddr_i[31:14];
  assign setup_c  = psel_i & ~penable_i;
  assign region_c = paddr_i[13:12];
  assign idx_c    = paddr_i[11:2];

  // Decode the setup-phase address into an error flag and a write-enable qualifier.
  always_comb begin
    range_err_c = 1'b0;
    case (region_c)
      2'd0:    range_err_c = 32'(idx_c) >= CH_MAP_DEPTH;
      2'd1:    range_err_c = 32'(idx_c) >= COL_MAP_DEPTH;
      2'd2:    range_err_c = 32'(idx_c) >= TIFF_DEPTH;
      default: range_err_c = 1'b1;
    endcase
    err_c = range_err_c || (paddr_i[1:0] != 2'd0) ||
            ((region_c == 2'd2) && pwrite_i && (pstrb_i != 4'hF));
    we_c  = pwrite_i && !err_c && ((region_c == 2'd2) || (pstrb_i != 4'h0));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      region_q    <= 2'd0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      cm_addr_q   <= '0;
      col_addr_q  <= '0;
      tf_addr_q   <= '0;
      cm_be_q     <= 4'h0;
      col_be_q    <= 4'h0;
      cm_wdata_q  <= 32'h0;
      col_wdata_q <= 32'h0;
      tf_wdata_q  <= 32'h0;
      cm_we_q     <= 1'b0;
      col_we_q    <= 1'b0;
      tf_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      write_q     <= write_d;
      err_q       <= err_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      cm_addr_q   <= cm_addr_d;
      col_addr_q  <= col_addr_d;
      tf_addr_q   <= tf_addr_d;
      cm_be_q     <= cm_be_d;
      col_be_q    <= col_be_d;
      cm_wdata_q  <= cm_wdata_d;
      col_wdata_q <= col_wdata_d;
      tf_wdata_q  <= tf_wdata_d;
      cm_we_q     <= cm_we_d;
      col_we_q    <= col_we_d;
      tf_we_q     <= tf_we_d;
    end
  end

  // Port registers load at the setup edge so address and we are valid throughout ISSUE.
  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    write_d     = write_q;
    err_d       = err_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    cm_addr_d   = cm_addr_q;
    col_addr_d  = col_addr_q;
    tf_addr_d   = tf_addr_q;
    cm_be_d     = cm_be_q;
    col_be_d    = col_be_q;
    cm_wdata_d  = cm_wdata_q;
    col_wdata_d = col_wdata_q;
    tf_wdata_d  = tf_wdata_q;
    cm_we_d     = 1'b0;
    col_we_d    = 1'b0;
    tf_we_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup_c) begin
          state_d  = S_ISSUE;
          region_d = region_c;
          write_d  = pwrite_i;
          err_d    = err_c;
          case (region_c)
            2'd0: begin
              cm_addr_d  = MEM_ADDR_W'(idx_c);
              cm_be_d    = pstrb_i;
              cm_wdata_d = pwdata_i;
              cm_we_d    = we_c;
            end
            2'd1: begin
              col_addr_d  = MEM_ADDR_W'(idx_c);
              col_be_d    = pstrb_i;
              col_wdata_d = pwdata_i;
              col_we_d    = we_c;
            end
            2'd2: begin
              tf_addr_d  = MEM_ADDR_W'(idx_c);
              tf_wdata_d = pwdata_i;
              tf_we_d    = we_c;
            end
            default: ;
          endcase
        end
      end
      S_ISSUE: begin
        state_d   = S_RESP;
        pready_d  = 1'b1;
        pslverr_d = err_q;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory read data is registered inside the memories, so it is valid for all of RESP.
  always_comb begin
    prdata_o = 32'h0;
    if ((state_q == S_RESP) && !write_q && !err_q) begin
      case (region_q)
        2'd0:    prdata_o = char_map_rdata_i;
        2'd1:    prdata_o = col_map_rdata_i;
        2'd2:    prdata_o = char_tiff_rdata_i;
        default: prdata_o = 32'h0;
      endcase
    end
  end

  assign pready_o          = pready_q;
  assign pslverr_o         = pslverr_q;
  assign char_map_addr_o   = cm_addr_q;
  assign char_map_we_o     = cm_we_q;
  assign char_map_be_o     = cm_be_q;
  assign char_map_wdata_o  = cm_wdata_q;
  assign col_map_addr_o    = col_addr_q;
  assign col_map_we_o      = col_we_q;
  assign col_map_be_o      = col_be_q;
  assign col_map_wdata_o   = col_wdata_q;
  assign char_tiff_addr_o  = tf_addr_q;
  assign char_tiff_we_o    = tf_we_q;
  assign char_tiff_wdata_o = tf_wdata_q;

endmodule

// File: tb/tb_apb_vgachargen_bridge.sv
// Bench for apb_vgachargen_bridge: behavioural memories, response scoreboard, vector table and sweeps.
module tb_apb_vgachargen_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = 32'h0, pwdata = 32'h0;
  logic [3:0] pstrb = 4'h0;
  logic pready_o, pslverr_o;
  logic [31:0] prdata_o;
  logic [9:0] cm_addr, col_addr, tf_addr;
  logic cm_we, col_we, tf_we;
  logic [3:0] cm_be, col_be;
  logic [31:0] cm_wdata, col_wdata, tf_wdata;
  logic [31:0] cm_rdata = 32'h0, col_rdata = 32'h0, tf_rdata = 32'h0;

  always #5 clk = ~clk;

  apb_vgachargen_bridge dut (
    .clk_i(clk), .rst_i(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .char_map_addr_o(cm_addr), .char_map_we_o(cm_we), .char_map_be_o(cm_be),
    .char_map_wdata_o(cm_wdata), .char_map_rdata_i(cm_rdata),
    .col_map_addr_o(col_addr), .col_map_we_o(col_we), .col_map_be_o(col_be),
    .col_map_wdata_o(col_wdata), .col_map_rdata_i(col_rdata),
    .char_tiff_addr_o(tf_addr), .char_tiff_we_o(tf_we),
    .char_tiff_wdata_o(tf_wdata), .char_tiff_rdata_i(tf_rdata)
  );

  logic [31:0] cm_mem [1024];
  logic [31:0] col_mem [1024];
  logic [31:0] tf_mem [1024];

  // Synchronous-read memories with byte enables, one-cycle read latency.
  always @(posedge clk) begin
    cm_rdata  <= cm_mem[cm_addr];
    col_rdata <= col_mem[col_addr];
    tf_rdata  <= tf_mem[tf_addr];
    if (cm_we)
      for (int b = 0; b < 4; b++) if (cm_be[b]) cm_mem[cm_addr][b*8 +: 8] <= cm_wdata[b*8 +: 8];
    if (col_we)
      for (int b = 0; b < 4; b++) if (col_be[b]) col_mem[col_addr][b*8 +: 8] <= col_wdata[b*8 +: 8];
    if (tf_we) tf_mem[tf_addr] <= tf_wdata;
  end

  int total = 0, passed = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  int cm_we_n = 0, col_we_n = 0, tf_we_n = 0;
  logic [9:0] cm_last_addr, col_last_addr, tf_last_addr;
  logic [3:0] cm_last_be, col_last_be;

  // Response monitor: pop the scoreboard on PREADY, and prdata must be 0 otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pready_o) begin
        if (sb_q.size() == 0) chk("unexpected_pready", 32'(pready_o), 32'h0);
        else begin
          sb_e = sb_q.pop_front();
          chk("prdata", prdata_o, sb_e.rdata);
          chk("pslverr", 32'(pslverr_o), 32'(sb_e.err));
        end
      end else chk("prdata_not_ready", prdata_o, 32'h0);
      if (cm_we)  begin cm_we_n++;  cm_last_addr = cm_addr;   cm_last_be = cm_be;   end
      if (col_we) begin col_we_n++; col_last_addr = col_addr; col_last_be = col_be; end
      if (tf_we)  begin tf_we_n++;  tf_last_addr = tf_addr; end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] erd, input logic eerr);
    int n;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    sb_q.push_back('{erd, eerr});
    @(posedge clk); #1;
    penable = 1'b1;
    chk("pready_in_issue", 32'(pready_o), 32'h0);
    n = 1;
    while (!pready_o && n < 6) begin @(posedge clk); #1; n++; end
    chk("wait_states", 32'(n), 32'd2);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;
    logic [31:0] exp_rdata; logic exp_err; int exp_port; logic [9:0] exp_idx;
  } vec_t;
  vec_t vecs[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2;
    vecs[0]  = '{1'b1, 32'h0000_0014, 32'hA5A5_0001, 4'hF, 32'h0,         1'b0,  0, 10'd5};
    vecs[1]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'hA5A5_0001, 1'b0, -1, 10'd0};
    vecs[2]  = '{1'b0, 32'h0000_0960, 32'h0,         4'h0, 32'h0,         1'b1, -1, 10'd0};
    vecs[3]  = '{1'b1, 32'h0000_0960, 32'h1111_1111, 4'hF, 32'h0,         1'b1, -1, 10'd0};
    vecs[4]  = '{1'b0, 32'h0000_3000, 32'h0,         4'h0, 32'h0,         1'b1, -1, 10'd0};
    vecs[5]  = '{1'b1, 32'h0000_3000, 32'h2222_2222, 4'hF, 32'h0,         1'b1, -1, 10'd0};
    vecs[6]  = '{1'b0, 32'h0000_0002, 32'h0,         4'h0, 32'h0,         1'b1, -1, 10'd0};
    vecs[7]  = '{1'b1, 32'h0000_0002, 32'h3333_3333, 4'hF, 32'h0,         1'b1, -1, 10'd0};
    vecs[8]  = '{1'b1, 32'h0000_2014, 32'hFFFF_FFFF, 4'h3, 32'h0,         1'b1, -1, 10'd0};
    vecs[9]  = '{1'b0, 32'h0000_2014, 32'h0,         4'h0, 32'h0000_0005, 1'b0, -1, 10'd0};
    vecs[10] = '{1'b1, 32'h0000_101C, 32'hDEAD_BEEF, 4'h4, 32'h0,         1'b0,  1, 10'd7};
    vecs[11] = '{1'b0, 32'h0000_101C, 32'h0,         4'h0, 32'h07AD_0707, 1'b0, -1, 10'd0};
    vecs[12] = '{1'b1, 32'h0000_101C, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, -1, 10'd0};
    vecs[13] = '{1'b0, 32'h0000_101C, 32'h0,         4'h0, 32'h07AD_0707, 1'b0, -1, 10'd0};
    vecs[14] = '{1'b1, 32'hFFFF_C014, 32'h1234_5678, 4'hF, 32'h0,         1'b0,  0, 10'd5};
    vecs[15] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h1234_5678, 1'b0, -1, 10'd0};
    vecs[16] = '{1'b0, 32'h0000_195C, 32'h0,         4'h0, 32'h5757_5757, 1'b0, -1, 10'd0};
    vecs[17] = '{1'b1, 32'h0000_2FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0,  2, 10'd1023};
    for (int i = 0; i < 1024; i++) begin cm_mem[i] = 32'h0; col_mem[i] = 32'h0; tf_mem[i] = 32'h0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", 32'(pready_o), 32'h0);
    chk("rst_pslverr", 32'(pslverr_o), 32'h0);
    chk("rst_prdata", prdata_o, 32'h0);
    chk("rst_addrs", 32'({cm_addr, col_addr, tf_addr}), 32'h0);
    chk("rst_wes", 32'({cm_we, col_we, tf_we}), 32'h0);
    chk("rst_wdata", cm_wdata | col_wdata | tf_wdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Reset asserted during the ISSUE of a write
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'h5A5A_5A5A; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("issue_we_before_rst", 32'(cm_we), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_we", 32'(cm_we), 32'h0);
    chk("rst_async_addr", 32'(cm_addr), 32'h0);
    chk("rst_async_be_wdata", 32'(cm_be) | cm_wdata, 32'h0);
    chk("rst_async_resp", 32'({pready_o, pslverr_o}) | prdata_o, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0);

    // Single char_map write: we must pulse for exactly one cycle
    c0 = cm_we_n;
    apb_xfer(1'b1, 32'h14, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0);
    chk("cm_we_pulse", 32'(cm_we_n - c0), 32'd1);
    chk("cm_we_addr", 32'(cm_last_addr), 32'd5);
    chk("cm_we_be", 32'(cm_last_be), 32'hF);

    // col_map sweep, back-to-back
    for (int i = 0; i < 600; i++) apb_xfer(1'b1, 32'h1000 + 32'(4 * i), {4{8'(i)}}, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 600; i++) apb_xfer(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0, {4{8'(i)}}, 1'b0);

    // char_tiff sweep
    for (int i = 0; i < 1024; i++) apb_xfer(1'b1, 32'h2000 + 32'(4 * i), 32'(i), 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 1024; i++) apb_xfer(1'b0, 32'h2000 + 32'(4 * i), 32'h0, 4'h0, 32'(i), 1'b0);

    // Vector table: errors, strobes, ignored upper address bits
    for (int v = 0; v < 18; v++) begin
      c0 = cm_we_n; c1 = col_we_n; c2 = tf_we_n;
      apb_xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, vecs[v].exp_rdata, vecs[v].exp_err);
      chk($sformatf("v%0d_cm_we", v), 32'(cm_we_n - c0), 32'(vecs[v].exp_port == 0));
      chk($sformatf("v%0d_col_we", v), 32'(col_we_n - c1), 32'(vecs[v].exp_port == 1));
      chk($sformatf("v%0d_tf_we", v), 32'(tf_we_n - c2), 32'(vecs[v].exp_port == 2));
      if (vecs[v].exp_port == 0) begin
        chk($sformatf("v%0d_cm_addr", v), 32'(cm_last_addr), 32'(vecs[v].exp_idx));
        chk($sformatf("v%0d_cm_be", v), 32'(cm_last_be), 32'(vecs[v].strb));
      end
      if (vecs[v].exp_port == 1) begin
        chk($sformatf("v%0d_col_addr", v), 32'(col_last_addr), 32'(vecs[v].exp_idx));
        chk($sformatf("v%0d_col_be", v), 32'(col_last_be), 32'(vecs[v].strb));
      end
      if (vecs[v].exp_port == 2) chk($sformatf("v%0d_tf_addr", v), 32'(tf_last_addr), 32'(vecs[v].exp_idx));
    end

    // Addresses hold between transfers; unselected ports keep theirs
    repeat (3) @(posedge clk);
    #1;
    chk("hold_cm_addr", 32'(cm_addr), 32'd5);
    chk("hold_col_addr", 32'(col_addr), 32'd599);
    chk("hold_tf_addr", 32'(tf_addr), 32'd1023);
    chk("hold_tf_wdata", tf_wdata, 32'hCAFE_F00D);

    // Stray PENABLE without setup is ignored
    penable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_penable", 32'(pready_o), 32'h0);
    penable = 1'b0;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
